// File: rtl/fp_add_sub_pipe_pkg.sv
// Shared FP constants, operand classification and unpacked-operand layout (binary32 defaults).
// Width-independent helpers so every pipeline instance can reuse them regardless of overrides.
package global_params;

   localparam int DEF_EXP_BITS  = 8;
   localparam int DEF_MANT_BITS = 23;
   localparam int DEF_BIAS      = 2**(DEF_EXP_BITS-1) - 1;
   localparam logic [DEF_EXP_BITS+DEF_MANT_BITS:0] DEF_QNAN =
      {1'b0, {DEF_EXP_BITS{1'b1}}, 1'b1, {(DEF_MANT_BITS-1){1'b0}}};

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

   typedef struct packed {
      logic                    sign;
      logic [DEF_EXP_BITS-1:0] exp;
      logic [DEF_MANT_BITS:0]  sig;
   } fp_unpacked_t;

   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic mant_zero);
      if (exp_ones) return mant_zero ? INF : NAN;
      if (exp_zero) return mant_zero ? ZERO : SUB;
      return NORM;
   endfunction

endpackage

// File: rtl/fp_add_sub_pipe_lzc.sv
// Leading-zero counter for the normalisation stage; an all-zero input reports W.
// Purely combinational, no handshake.
module fp_lzc #(
   parameter int W  = 27,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  i_vec,
   output logic [CW-1:0] o_cnt
);

   // Scan upward so the highest set bit is the last one to win.
   always_comb begin
      o_cnt = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (i_vec[i]) o_cnt = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// IEEE-754 add/subtract, RNE, subnormal/inf/NaN aware; FP_ADD_SUB_FLAGS_EN adds flags[3:0] output.
// Latency 3 cycles (unpack/align, add/normalise, round/pack), throughput 1 per cycle.
// Backpressure: whole pipe stalls while out_valid && !out_ready; in_ready mirrors that.
module fp_add_sub_pipe
   import global_params::*;
#(
   parameter int EXP_BITS  = DEF_EXP_BITS,
   parameter int MANT_BITS = DEF_MANT_BITS,
   parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             operation_select,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef FP_ADD_SUB_FLAGS_EN
   output logic [3:0]       flags,
`endif
   output logic [WIDTH-1:0] result
);

   localparam int SIG = MANT_BITS + 4;
   localparam int LZW = $clog2(SIG + 1);
   localparam int EW  = EXP_BITS + 1;
   localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
   localparam logic [EW-1:0]       EXP_MAX  = {1'b0, {EXP_BITS{1'b1}}};
   localparam logic [WIDTH-1:0]    QNAN_W   =
      {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

   logic w_adv;

   logic                 r1_vld, r1_sx, r1_sy, r1_spec;
   logic [EXP_BITS-1:0]  r1_ex;
   logic [SIG-1:0]       r1_sig_x, r1_sig_y;
   logic [WIDTH-1:0]     r1_spec_val;

   logic                 r2_vld, r2_sign, r2_spec;
   logic [EW-1:0]        r2_exp;
   logic [SIG-1:0]       r2_sig;
   logic [WIDTH-1:0]     r2_spec_val;

   logic                 r3_vld;
   logic [WIDTH-1:0]     r3_res;

   assign w_adv     = !r3_vld || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r3_vld;
   assign result    = r3_res;

   // ---------------- S1: unpack, classify, swap, align ----------------
   logic                 w_sa, w_sb, w_swap, w_inf_inf;
   logic [EXP_BITS-1:0]  w_ea, w_eb;
   logic [MANT_BITS-1:0] w_ma, w_mb;
   fp_class_e            w_ca, w_cb;
   logic                 w_spec;
   logic [WIDTH-1:0]     w_spec_val;

   assign w_sa = a[WIDTH-1];
   assign w_sb = b[WIDTH-1] ^ operation_select;
   assign w_ea = a[WIDTH-2 -: EXP_BITS];
   assign w_eb = b[WIDTH-2 -: EXP_BITS];
   assign w_ma = a[MANT_BITS-1:0];
   assign w_mb = b[MANT_BITS-1:0];
   assign w_ca = fp_classify(w_ea == '0, w_ea == EXP_ONES, w_ma == '0);
   assign w_cb = fp_classify(w_eb == '0, w_eb == EXP_ONES, w_mb == '0);
   assign w_inf_inf = (w_ca == INF) && (w_cb == INF) && (w_sa != w_sb);

   always_comb begin
      w_spec     = 1'b0;
      w_spec_val = QNAN_W;
      if (w_ca == NAN || w_cb == NAN || w_inf_inf) begin
         w_spec = 1'b1;
      end else if (w_ca == INF) begin
         w_spec     = 1'b1;
         w_spec_val = {w_sa, EXP_ONES, {MANT_BITS{1'b0}}};
      end else if (w_cb == INF) begin
         w_spec     = 1'b1;
         w_spec_val = {w_sb, EXP_ONES, {MANT_BITS{1'b0}}};
      end
   end

   logic                 w_sx, w_sy, w_hx, w_hy;
   logic [EXP_BITS-1:0]  w_ex_raw, w_ey_raw, w_ex, w_ey, w_diff;
   logic [MANT_BITS-1:0] w_mx, w_my;
   logic [SIG-1:0]       w_sig_x, w_sig_y_full, w_sig_y_sh, w_sig_y;
   logic                 w_lost;

   // Magnitude order of the packed {exp, mant} fields matches numeric order.
   assign w_swap   = b[WIDTH-2:0] > a[WIDTH-2:0];
   assign w_sx     = w_swap ? w_sb : w_sa;
   assign w_sy     = w_swap ? w_sa : w_sb;
   assign w_ex_raw = w_swap ? w_eb : w_ea;
   assign w_ey_raw = w_swap ? w_ea : w_eb;
   assign w_mx     = w_swap ? w_mb : w_ma;
   assign w_my     = w_swap ? w_ma : w_mb;
   assign w_hx     = w_ex_raw != '0;
   assign w_hy     = w_ey_raw != '0;
   assign w_ex     = w_hx ? w_ex_raw : {{(EXP_BITS-1){1'b0}}, 1'b1};
   assign w_ey     = w_hy ? w_ey_raw : {{(EXP_BITS-1){1'b0}}, 1'b1};
   assign w_diff   = w_ex - w_ey;

   assign w_sig_x      = {w_hx, w_mx, 3'b000};
   assign w_sig_y_full = {w_hy, w_my, 3'b000};
   assign w_sig_y_sh   = w_sig_y_full >> w_diff;
   assign w_lost       = |(w_sig_y_full & ~({SIG{1'b1}} << w_diff));
   assign w_sig_y      = {w_sig_y_sh[SIG-1:1], w_sig_y_sh[0] | w_lost};

   // ---------------- S2: add/subtract, normalise ----------------
   logic             w_eff_sub, w_n_sign;
   logic [SIG:0]     w_sum;
   logic [LZW-1:0]   w_lzc;
   logic [EW-1:0]    w_emax_sh, w_sh, w_n_exp;
   logic [SIG-1:0]   w_n_sig;

   assign w_eff_sub = r1_sx ^ r1_sy;
   assign w_sum     = w_eff_sub ? ({1'b0, r1_sig_x} - {1'b0, r1_sig_y})
                                : ({1'b0, r1_sig_x} + {1'b0, r1_sig_y});

   fp_lzc #(.W(SIG), .CW(LZW)) u_lzc (
      .i_vec (w_sum[SIG-1:0]),
      .o_cnt (w_lzc)
   );

   // Stop normalising at exponent 1 so tiny results stay subnormal.
   assign w_emax_sh = {1'b0, r1_ex} - EW'(1);
   assign w_sh      = (EW'(w_lzc) > w_emax_sh) ? w_emax_sh : EW'(w_lzc);

   always_comb begin
      w_n_sig = '0;
      w_n_exp = '0;
      if (w_sum[SIG]) begin
         w_n_sig = {w_sum[SIG:2], w_sum[1] | w_sum[0]};
         w_n_exp = {1'b0, r1_ex} + EW'(1);
      end else begin
         w_n_sig = w_sum[SIG-1:0] << w_sh;
         w_n_exp = {1'b0, r1_ex} - w_sh;
      end
   end

   // Exact cancellation gives +0; only two same-signed zeros keep their sign.
   assign w_n_sign = (w_sum == '0) ? (r1_sx & r1_sy) : r1_sx;

   // ---------------- S3: round to nearest even, pack ----------------
   logic                 w_g, w_rs, w_inc, w_r_hid, w_ovf;
   logic [MANT_BITS+1:0] w_rnd;
   logic [EW-1:0]        w_r_exp;
   logic [MANT_BITS-1:0] w_r_man;
   logic [WIDTH-1:0]     w_res;

   assign w_g     = r2_sig[2];
   assign w_rs    = r2_sig[1] | r2_sig[0];
   assign w_inc   = w_g & (w_rs | r2_sig[3]);
   assign w_rnd   = {1'b0, r2_sig[SIG-1:3]} + {{(MANT_BITS+1){1'b0}}, w_inc};
   assign w_r_exp = r2_exp + {{(EW-1){1'b0}}, w_rnd[MANT_BITS+1]};
   assign w_r_man = w_rnd[MANT_BITS+1] ? w_rnd[MANT_BITS:1] : w_rnd[MANT_BITS-1:0];
   assign w_r_hid = w_rnd[MANT_BITS+1] | w_rnd[MANT_BITS];
   assign w_ovf   = w_r_exp >= EXP_MAX;

   always_comb begin
      w_res = {r2_sign, (w_r_hid ? w_r_exp[EXP_BITS-1:0] : {EXP_BITS{1'b0}}), w_r_man};
      if (r2_spec)    w_res = r2_spec_val;
      else if (w_ovf) w_res = {r2_sign, EXP_ONES, {MANT_BITS{1'b0}}};
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_vld <= 1'b0;
         r2_vld <= 1'b0;
         r3_vld <= 1'b0;
         r3_res <= '0;
      end else if (w_adv) begin
         r1_vld <= in_valid;
         r2_vld <= r1_vld;
         r3_vld <= r2_vld;
         if (r2_vld) r3_res <= w_res;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r1_sx       <= w_sx;
         r1_sy       <= w_sy;
         r1_ex       <= w_ex;
         r1_sig_x    <= w_sig_x;
         r1_sig_y    <= w_sig_y;
         r1_spec     <= w_spec;
         r1_spec_val <= w_spec_val;
         r2_sign     <= w_n_sign;
         r2_exp      <= w_n_exp;
         r2_sig      <= w_n_sig;
         r2_spec     <= r1_spec;
         r2_spec_val <= r1_spec_val;
      end
   end

`ifdef FP_ADD_SUB_FLAGS_EN
   logic       w_snan, r1_invalid, r2_invalid, w_f_inexact;
   logic [3:0] r3_flags, w_flags;

   assign w_snan = (w_ca == NAN && !w_ma[MANT_BITS-1]) || (w_cb == NAN && !w_mb[MANT_BITS-1]);
   assign w_f_inexact = !r2_spec && (w_g || w_rs || w_ovf);
   // Tiny means still subnormal before rounding; only a problem when inexact.
   assign w_flags = {r2_invalid,
                     !r2_spec && w_ovf,
                     !r2_spec && !r2_sig[SIG-1] && (w_g || w_rs),
                     w_f_inexact};
   assign flags = r3_flags;

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r1_invalid <= w_inf_inf || w_snan;
         r2_invalid <= r1_invalid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r3_flags <= '0;
      else if (w_adv && r2_vld)  r3_flags <= w_flags;
   end
`endif

endmodule
